// File: rtl/pwm_ctrl_pkg.sv
// pwm_ctrl_pkg
// Shared constants for the PWM control engine. This covers the bit positions
// inside the 32-bit control word and the 8-bit status word, the register
// select codes, and one helper that decides whether a select code names a
// writable register.
// There are no ports. Other files use it through import pwm_ctrl_pkg::*.
package pwm_ctrl_pkg;

  // Bit positions in the control word.
  localparam int CTRL_EN      = 31;
  localparam int CTRL_INV     = 30;
  localparam int CTRL_COMMIT  = 29;
  localparam int CTRL_SEL_HI  = 27;
  localparam int CTRL_SEL_LO  = 24;
  localparam int CTRL_DATA_HI = 15;
  localparam int CTRL_DATA_LO = 0;

  // Register select codes.
  localparam logic [3:0] SEL_DUTY0  = 4'd0;
  localparam logic [3:0] SEL_DUTY1  = 4'd1;
  localparam logic [3:0] SEL_DUTY2  = 4'd2;
  localparam logic [3:0] SEL_DUTY3  = 4'd3;
  localparam logic [3:0] SEL_PERIOD = 4'd4;
  localparam logic [3:0] SEL_PRESC  = 4'd5;

  // Bit positions in the status word.
  localparam int ST_OUT_HI = 3;
  localparam int ST_OUT_LO = 0;
  localparam int ST_EN     = 4;
  localparam int ST_PEND   = 5;
  localparam int ST_WRAP   = 6;
  localparam int ST_ERR    = 7;

  // A duty select is writable only if that channel exists.
  function automatic logic sel_valid(input logic [3:0] sel, input int n_ch);
    return (int'(sel) < n_ch) || (sel == SEL_PERIOD) || (sel == SEL_PRESC);
  endfunction

endpackage

// File: rtl/pwm_ctrl_engine_prescaler.sv
// pwm_prescaler
// Clock divider for the PWM period counter. The internal counter runs from 0
// to presc_i. The last count raises tick_o and the counter then wraps to 0,
// so a tick arrives every presc_i+1 clocks. While en_i is low the counter is
// held at 0, so a fresh enable always begins a full prescale interval.
// Ports:
//   clk_i    system clock
//   rst_ni   asynchronous active-low reset
//   en_i     count enable
//   presc_i  active prescaler value
//   tick_o   one-clock pulse on the last count (combinational)
module pwm_prescaler #(
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  input  logic [CNT_W-1:0] presc_i,
  output logic             tick_o
);

  logic [CNT_W-1:0] pcnt_q, pcnt_d;

  assign tick_o = en_i && (pcnt_q == presc_i);

  always_comb begin
    pcnt_d = pcnt_q;
    if (!en_i) begin
      pcnt_d = '0;
    end else if (tick_o) begin
      pcnt_d = '0;
    end else begin
      pcnt_d = pcnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pcnt_q <= '0;
    end else begin
      pcnt_q <= pcnt_d;
    end
  end

endmodule

// File: rtl/pwm_ctrl_engine.sv
// pwm_ctrl_engine
// Receives the PWM control PIO word and drives N_CH PWM pins.
// A rising edge on the commit bit writes the data field into the selected
// shadow register. A write takes effect at the clock edge that samples the
// commit bit high while the previous sample was low. The shadow registers move
// into the active set only when the period counter wraps, or on every cycle
// while the engine is disabled. Because of this, a running waveform never
// sees a partial update.
// Ports:
//   clk_clk        system clock
//   reset_reset_n  asynchronous active-low reset
//   pwm_ctrl       control word {en, inv, commit, rsvd, sel[3:0], rsvd[7:0], data[15:0]}
//   pwm_status     status word  {err, wrap_tgl, pending, enable, pwm_out[3:0]}
//   pwm_out        registered PWM outputs
module pwm_ctrl_engine
  import pwm_ctrl_pkg::*;
#(
  parameter int N_CH       = 4,
  parameter int CNT_W      = 16,
  parameter int RST_PERIOD = 999,
  parameter int RST_PRESC  = 49
) (
  input  logic            clk_clk,
  input  logic            reset_reset_n,
  input  logic [31:0]     pwm_ctrl,
  output logic [7:0]      pwm_status,
  output logic [N_CH-1:0] pwm_out
);

  // Control word fields
  logic             en, inv, commit;
  logic [3:0]       sel;
  logic [CNT_W-1:0] data_c;
  logic             unused_ctrl;

  assign en          = pwm_ctrl[CTRL_EN];
  assign inv         = pwm_ctrl[CTRL_INV];
  assign commit      = pwm_ctrl[CTRL_COMMIT];
  assign sel         = pwm_ctrl[CTRL_SEL_HI:CTRL_SEL_LO];
  assign data_c      = CNT_W'(pwm_ctrl[CTRL_DATA_HI:CTRL_DATA_LO]);
  assign unused_ctrl = ^{pwm_ctrl[28], pwm_ctrl[23:16]};

  // State
  logic                        commit_prev_q;
  logic [N_CH-1:0][CNT_W-1:0]  duty_sh_q, duty_sh_d, duty_act_q, duty_act_d;
  logic [CNT_W-1:0]            period_sh_q, period_sh_d, period_act_q, period_act_d;
  logic [CNT_W-1:0]            presc_sh_q, presc_sh_d, presc_act_q, presc_act_d;
  logic [CNT_W-1:0]            cnt_q, cnt_d;
  logic                        pending_q, pending_d;
  logic                        err_q, err_d;
  logic                        wrap_tgl_q, wrap_tgl_d;
  logic                        en_q;
  logic [N_CH-1:0]             pwm_out_q, pwm_out_d;

  // Commit decode
  logic commit_edge, wr_ok, wr_bad;

  assign commit_edge = commit && !commit_prev_q;
  assign wr_ok       = commit_edge && sel_valid(sel, N_CH);
  assign wr_bad      = commit_edge && !sel_valid(sel, N_CH);

  // Timebase
  logic tick, at_top, wrap, xfer;

  pwm_prescaler #(.CNT_W(CNT_W)) u_presc (
    .clk_i   (clk_clk),
    .rst_ni  (reset_reset_n),
    .en_i    (en),
    .presc_i (presc_act_q),
    .tick_o  (tick)
  );

  assign at_top = (cnt_q == period_act_q);
  assign wrap   = tick && at_top;
  // While disabled the actives follow the shadows on every cycle. A later
  // enable therefore starts with whatever was last committed.
  assign xfer   = !en || wrap;

  always_comb begin
    cnt_d = cnt_q;
    if (!en) begin
      cnt_d = '0;
    end else if (tick) begin
      cnt_d = at_top ? '0 : cnt_q + CNT_W'(1);
    end
  end

  // Register file. The transfer reads the current shadow values, so when a
  // commit lands in the same cycle the actives take the pre-commit values and
  // the new value stays pending until the next transfer.
  always_comb begin
    duty_sh_d    = duty_sh_q;
    duty_act_d   = duty_act_q;
    period_sh_d  = period_sh_q;
    period_act_d = period_act_q;
    presc_sh_d   = presc_sh_q;
    presc_act_d  = presc_act_q;
    pending_d    = pending_q;
    err_d        = err_q;

    if (xfer) begin
      duty_act_d   = duty_sh_q;
      period_act_d = period_sh_q;
      presc_act_d  = presc_sh_q;
      pending_d    = 1'b0;
    end

    if (wr_ok) begin
      if (sel == SEL_PERIOD) begin
        period_sh_d = data_c;
      end else if (sel == SEL_PRESC) begin
        presc_sh_d = data_c;
      end else begin
        for (int i = 0; i < N_CH; i++) begin
          if (sel == 4'(i)) duty_sh_d[i] = data_c;
        end
      end
      pending_d = 1'b1;
      err_d     = 1'b0;
    end else if (wr_bad) begin
      err_d = 1'b1;
    end
  end

  assign wrap_tgl_d = wrap ? !wrap_tgl_q : wrap_tgl_q;

  // Compare stage
  logic [N_CH-1:0] raw;

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    assign raw[g] = (cnt_q < duty_act_q[g]);
  end

  assign pwm_out_d = en ? (raw ^ {N_CH{inv}}) : {N_CH{inv}};

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      commit_prev_q <= 1'b0;
      duty_sh_q     <= '0;
      duty_act_q    <= '0;
      period_sh_q   <= CNT_W'(RST_PERIOD);
      period_act_q  <= CNT_W'(RST_PERIOD);
      presc_sh_q    <= CNT_W'(RST_PRESC);
      presc_act_q   <= CNT_W'(RST_PRESC);
      cnt_q         <= '0;
      pending_q     <= 1'b0;
      err_q         <= 1'b0;
      wrap_tgl_q    <= 1'b0;
      en_q          <= 1'b0;
      pwm_out_q     <= '0;
    end else begin
      commit_prev_q <= commit;
      duty_sh_q     <= duty_sh_d;
      duty_act_q    <= duty_act_d;
      period_sh_q   <= period_sh_d;
      period_act_q  <= period_act_d;
      presc_sh_q    <= presc_sh_d;
      presc_act_q   <= presc_act_d;
      cnt_q         <= cnt_d;
      pending_q     <= pending_d;
      err_q         <= err_d;
      wrap_tgl_q    <= wrap_tgl_d;
      en_q          <= en;
      pwm_out_q     <= pwm_out_d;
    end
  end

  // Status
  logic [3:0] out_pad;

  always_comb begin
    out_pad             = '0;
    out_pad[N_CH-1:0]   = pwm_out_q;
    pwm_status                     = '0;
    pwm_status[ST_OUT_HI:ST_OUT_LO] = out_pad;
    pwm_status[ST_EN]              = en_q;
    pwm_status[ST_PEND]            = pending_q;
    pwm_status[ST_WRAP]            = wrap_tgl_q;
    pwm_status[ST_ERR]             = err_q;
  end

  assign pwm_out = pwm_out_q;

endmodule

// File: tb/tb_pwm_ctrl_engine.sv
// Testbench for pwm_ctrl_engine.
module tb_pwm_ctrl_engine;
  localparam int N_CH  = 4;
  localparam int CNT_W = 16;

  // Clock / reset
  logic            clk = 1'b0;
  logic            rst_n;
  logic [31:0]     ctrl;
  logic [7:0]      status;
  logic [N_CH-1:0] pout;

  always #5 clk = ~clk;

  pwm_ctrl_engine #(
    .N_CH(N_CH), .CNT_W(CNT_W), .RST_PERIOD(999), .RST_PRESC(49)
  ) dut (
    .clk_clk       (clk),
    .reset_reset_n (rst_n),
    .pwm_ctrl      (ctrl),
    .pwm_status    (status),
    .pwm_out       (pout)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: plain integers
  int         m_pcnt, m_cnt, m_per_sh, m_per_ac, m_pre_sh, m_pre_ac;
  int         m_duty_sh[N_CH];
  int         m_duty_ac[N_CH];
  bit         m_prev, m_pend, m_err, m_tgl, m_en;
  logic [3:0] m_out;

  // Scoreboard: expected {status, pwm_out} per clock
  logic [11:0] exp_q[$];
  logic [11:0] obs_w, exp_w;
  int          ph;  // bench-side phase (cnt before the next edge) for period-9 runs

  function automatic void m_reset();
    m_pcnt = 0; m_cnt = 0;
    m_per_sh = 999; m_per_ac = 999; m_pre_sh = 49; m_pre_ac = 49;
    for (int i = 0; i < N_CH; i++) begin m_duty_sh[i] = 0; m_duty_ac[i] = 0; end
    m_prev = 0; m_pend = 0; m_err = 0; m_tgl = 0; m_en = 0; m_out = '0;
    exp_q.delete();
  endfunction

  function automatic void m_step(input logic [31:0] c);
    bit en, inv, cm, edge_s, ok, tick, wrap;
    int sel, d;
    en = c[31]; inv = c[30]; cm = c[29];
    sel = int'(c[27:24]); d = int'(c[15:0]);
    for (int i = 0; i < N_CH; i++) m_out[i] = en ? ((m_cnt < m_duty_ac[i]) ^ inv) : inv;
    edge_s = cm && !m_prev;
    ok     = (sel < N_CH) || (sel == 4) || (sel == 5);
    tick   = en && (m_pcnt == m_pre_ac);
    wrap   = tick && (m_cnt == m_per_ac);
    if (!en) begin m_pcnt = 0; m_cnt = 0; end
    else if (tick) begin m_pcnt = 0; m_cnt = wrap ? 0 : m_cnt + 1; end
    else m_pcnt = m_pcnt + 1;
    if (!en || wrap) begin
      for (int i = 0; i < N_CH; i++) m_duty_ac[i] = m_duty_sh[i];
      m_per_ac = m_per_sh; m_pre_ac = m_pre_sh; m_pend = 0;
    end
    if (edge_s && ok) begin
      if (sel == 4) m_per_sh = d;
      else if (sel == 5) m_pre_sh = d;
      else m_duty_sh[sel] = d;
      m_pend = 1; m_err = 0;
    end else if (edge_s) begin
      m_err = 1;
    end
    if (wrap) m_tgl = !m_tgl;
    m_prev = cm; m_en = en;
    exp_q.push_back({m_err, m_tgl, m_pend, m_en, m_out, m_out});
  endfunction

  function automatic logic [31:0] mk(bit en, bit inv, bit cm, logic [3:0] sel, logic [15:0] d);
    return {en, inv, cm, 1'b0, sel, 8'h00, d};
  endfunction

  // Driver tasks
  task automatic step(input logic [31:0] c);
    ctrl = c;
    @(posedge clk);
    m_step(c);
    #1;
    obs_w = {status, pout};
    exp_w = exp_q.pop_front();
    ph = (ph == 9) ? 0 : ph + 1;
  endtask

  task automatic commit_w(input bit en, input bit inv, input logic [3:0] sel, input logic [15:0] d);
    step(mk(en, inv, 1'b1, sel, d));
    step(mk(en, inv, 1'b0, sel, d));
  endtask

  // Tests
  task automatic test_reset();
    rst_n = 1'b0;
    ctrl  = '0;
    m_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++; if (pout !== 4'h0) begin errors++; $display("FAIL reset_out got=%h exp=0", pout); end
    checks++; if (status !== 8'h00) begin errors++; $display("FAIL reset_status got=%h exp=00", status); end
    rst_n = 1'b1;
  endtask

  task automatic test_defaults();
    int n;
    n = 0;
    for (int i = 1; i <= 60000; i++) begin
      step(mk(1, 0, 0, 4'd0, 16'd0));
      checks++; if (obs_w !== exp_w) begin errors++; $display("FAIL defaults_model cyc=%0d got=%h exp=%h", i, obs_w, exp_w); end
      checks++; if (pout !== 4'h0) begin errors++; $display("FAIL defaults_out cyc=%0d got=%h exp=0", i, pout); end
      if (status[6]) begin n = i; break; end
    end
    checks++; if (n != 50000) begin errors++; $display("FAIL defaults_wrap_cycle got=%0d exp=50000", n); end
  endtask

  task automatic test_basic();
    int p;
    step(mk(0, 0, 0, 4'd0, 16'd0));
    commit_w(0, 0, 4'd5, 16'd0);
    commit_w(0, 0, 4'd4, 16'd9);
    commit_w(0, 0, 4'd0, 16'd3);
    step(mk(0, 0, 0, 4'd0, 16'd0));
    ph = 0;
    for (int k = 0; k < 30; k++) begin
      p = ph;
      step(mk(1, 0, 0, 4'd0, 16'd0));
      checks++; if (obs_w !== exp_w) begin errors++; $display("FAIL basic_model k=%0d got=%h exp=%h", k, obs_w, exp_w); end
      checks++; if (pout !== {3'b000, 1'(p < 3)}) begin errors++; $display("FAIL basic_wave k=%0d got=%h exp_bit0=%0d", k, pout, (p < 3)); end
    end
  endtask

  task automatic test_glitch_free();
    int p;
    bit wrapped;
    while (ph != 5) begin
      step(mk(1, 0, 0, 4'd0, 16'd0));
      checks++; if (obs_w !== exp_w) begin errors++; $display("FAIL glitch_pre got=%h exp=%h", obs_w, exp_w); end
    end
    step(mk(1, 0, 1, 4'd0, 16'd7));
    checks++; if (status[5] !== 1'b1) begin errors++; $display("FAIL glitch_pending_set got=%b exp=1", status[5]); end
    wrapped = 0;
    for (int i = 0; i < 15; i++) begin
      p = ph;
      step(mk(1, 0, 0, 4'd0, 16'd7));
      checks++; if (obs_w !== exp_w) begin errors++; $display("FAIL glitch_model i=%0d got=%h exp=%h", i, obs_w, exp_w); end
      checks++; if (pout[0] !== 1'(p < (wrapped ? 7 : 3))) begin errors++; $display("FAIL glitch_wave i=%0d got=%b exp=%0d", i, pout[0], (p < (wrapped ? 7 : 3))); end
      if (p == 9) wrapped = 1;
      checks++; if (status[5] !== !wrapped) begin errors++; $display("FAIL glitch_pending i=%0d got=%b exp=%b", i, status[5], !wrapped); end
    end
  endtask

  task automatic test_collision();
    int p;
    while (ph != 9) begin
      step(mk(1, 0, 0, 4'd0, 16'd0));
      checks++; if (obs_w !== exp_w) begin errors++; $display("FAIL coll_pre got=%h exp=%h", obs_w, exp_w); end
    end
    step(mk(1, 0, 1, 4'd1, 16'd5));
    checks++; if (status[5] !== 1'b1) begin errors++; $display("FAIL coll_pending_kept got=%b exp=1", status[5]); end
    for (int i = 0; i < 20; i++) begin
      p = ph;
      step(mk(1, 0, 0, 4'd1, 16'd5));
      checks++; if (obs_w !== exp_w) begin errors++; $display("FAIL coll_model i=%0d got=%h exp=%h", i, obs_w, exp_w); end
      checks++; if (pout[1] !== ((i < 10) ? 1'b0 : 1'(p < 5))) begin errors++; $display("FAIL coll_wave i=%0d got=%b", i, pout[1]); end
      checks++; if (status[5] !== 1'(i < 9)) begin errors++; $display("FAIL coll_pending i=%0d got=%b exp=%0d", i, status[5], (i < 9)); end
    end
  endtask

  task automatic test_error();
    int h0, h1, h2;
    step(mk(1, 0, 1, 4'd9, 16'd2));
    checks++; if (status[7] !== 1'b1) begin errors++; $display("FAIL err_set got=%b exp=1", status[7]); end
    checks++; if (status[5] !== 1'b0) begin errors++; $display("FAIL err_no_pending got=%b exp=0", status[5]); end
    step(mk(1, 0, 0, 4'd0, 16'd0));
    step(mk(1, 0, 1, 4'd2, 16'd4));
    checks++; if (status[7] !== 1'b0) begin errors++; $display("FAIL err_clear got=%b exp=0", status[7]); end
    for (int i = 0; i < 19; i++) begin
      step(mk(1, 0, 1, 4'd2, 16'($urandom_range(5, 15))));
      checks++; if (obs_w !== exp_w) begin errors++; $display("FAIL hold_model i=%0d got=%h exp=%h", i, obs_w, exp_w); end
    end
    while (ph != 0) begin
      step(mk(1, 0, 0, 4'd0, 16'd0));
      checks++; if (obs_w !== exp_w) begin errors++; $display("FAIL hold_align got=%h exp=%h", obs_w, exp_w); end
    end
    h0 = 0; h1 = 0; h2 = 0;
    for (int i = 0; i < 10; i++) begin
      step(mk(1, 0, 0, 4'd0, 16'd0));
      checks++; if (obs_w !== exp_w) begin errors++; $display("FAIL hold_period i=%0d got=%h exp=%h", i, obs_w, exp_w); end
      h0 += int'(pout[0]); h1 += int'(pout[1]); h2 += int'(pout[2]);
    end
    checks++; if (h0 != 7) begin errors++; $display("FAIL err_ch0_highs got=%0d exp=7", h0); end
    checks++; if (h1 != 5) begin errors++; $display("FAIL err_ch1_highs got=%0d exp=5", h1); end
    checks++; if (h2 != 4) begin errors++; $display("FAIL hold_once_ch2_highs got=%0d exp=4", h2); end
  endtask

  task automatic test_invert_bounds();
    step(mk(0, 1, 0, 4'd0, 16'd0));
    step(mk(0, 1, 0, 4'd0, 16'd0));
    checks++; if (pout !== 4'hF) begin errors++; $display("FAIL inv_dis_out got=%h exp=f", pout); end
    checks++; if (status[4:0] !== 5'h0F) begin errors++; $display("FAIL inv_dis_status got=%h exp=0f", status[4:0]); end
    commit_w(0, 1, 4'd3, 16'd10);
    step(mk(0, 0, 0, 4'd0, 16'd0));
    ph = 0;
    for (int i = 0; i < 20; i++) begin
      step(mk(1, (i >= 10), 0, 4'd0, 16'd0));
      checks++; if (obs_w !== exp_w) begin errors++; $display("FAIL bound_model i=%0d got=%h exp=%h", i, obs_w, exp_w); end
      checks++; if (pout[3] !== 1'(i < 10)) begin errors++; $display("FAIL bound_duty_gt_period i=%0d got=%b exp=%0d", i, pout[3], (i < 10)); end
    end
  endtask

  task automatic test_random();
    bit cm;
    logic [3:0] sel;
    cm = 0;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 2) == 0) cm = !cm;
      sel = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(6, 15)) : 4'($urandom_range(0, 5));
      step(mk(($urandom_range(0, 7) != 0), 1'($urandom_range(0, 1)), cm, sel, 16'($urandom_range(0, 12))));
      checks++; if (obs_w !== exp_w) begin errors++; $display("FAIL random_model i=%0d got=%h exp=%h", i, obs_w, exp_w); end
    end
  endtask

  task automatic test_reset_mid();
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (pout !== 4'h0) begin errors++; $display("FAIL rstmid_out got=%h exp=0", pout); end
    checks++; if (status !== 8'h00) begin errors++; $display("FAIL rstmid_status got=%h exp=00", status); end
    m_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 30; i++) begin
      step(mk(1, 0, 0, 4'd0, 16'd0));
      checks++; if (obs_w !== exp_w) begin errors++; $display("FAIL rstmid_model i=%0d got=%h exp=%h", i, obs_w, exp_w); end
    end
  endtask

  initial begin
    ph = 0;
    test_reset();
    test_defaults();
    test_basic();
    test_glitch_free();
    test_collision();
    test_error();
    test_invert_bounds();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
